// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - ISA encodings, legality screen and issuer FSM states (ISSUE_TIMEOUT_EN adds HALT)
package cpu_isa_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_BUSY
`ifdef ISSUE_TIMEOUT_EN
    , S_HALT
`endif
  } state_t;

  // key is {opcode, op} = word[15:11]; only encodings the cpu controller decodes pass
  function automatic logic is_legal(input logic [4:0] key);
    logic ok;
    ok = 1'b0;
    if (key == {OPC_MOV, OP_MOV_IMM}) ok = 1'b1;
    if (key == {OPC_MOV, OP_MOV_REG}) ok = 1'b1;
    if (key == {OPC_ALU, OP_ADD})     ok = 1'b1;
    if (key == {OPC_ALU, OP_CMP})     ok = 1'b1;
    if (key == {OPC_ALU, OP_AND})     ok = 1'b1;
    if (key == {OPC_ALU, OP_MVN})     ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - instruction buffer with sticky overflow flag
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        pop,
  output logic [15:0] rd_data,
  output logic        empty,
  output logic        full,
  output logic        ovf
);

  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push is accepted even when full
  assign do_push = wr_en & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // storage writes; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (wr_en && full && !do_pop) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_instr_issuer.sv
// rtl/cpu_instr_issuer.sv - buffered load/s/w instruction issuer; ISSUE_TIMEOUT_EN enables hang detection
module cpu_instr_issuer
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        run,
  input  logic        cpu_w,
  output logic [15:0] cpu_in,
  output logic        cpu_load,
  output logic        cpu_s,
  output logic        busy,
  output logic        done,
  output logic        empty,
  output logic        full,
  output logic        err_illegal,
  output logic        err_ovf,
  output logic        err_timeout,
  output logic [7:0]  issued_cnt
);

  state_t      state;
  state_t      next_state;
  logic [15:0] head;
  logic        pop;
  logic        load_in;
  logic        set_illegal;
  logic        set_timeout;
  logic        count_done;

  instr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .empty   (empty),
    .full    (full),
    .ovf     (err_ovf)
  );

`ifdef ISSUE_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_hit;

  assign to_hit = (to_cnt == 8'(TIMEOUT - 1));

  // busy-cycle counter, restarted each START
  always_ff @(posedge clk) begin
    if (reset)                 to_cnt <= '0;
    else if (state == S_START) to_cnt <= '0;
    else if (state == S_BUSY)  to_cnt <= to_cnt + 1'b1;
  end

  // sticky hang flag
  always_ff @(posedge clk) begin
    if (reset)            err_timeout <= 1'b0;
    else if (set_timeout) err_timeout <= 1'b1;
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign err_timeout    = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // next-state and handshake strobes
  always_comb begin
    next_state  = state;
    cpu_load    = 1'b0;
    cpu_s       = 1'b0;
    done        = 1'b0;
    pop         = 1'b0;
    load_in     = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    count_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && run && cpu_w) begin
          if (is_legal(head[15:11])) begin
            next_state = S_LOAD;
            load_in    = 1'b1;
          end else begin
            pop         = 1'b1;
            set_illegal = 1'b1;
          end
        end
      end
      S_LOAD: begin
        cpu_load   = 1'b1;
        pop        = 1'b1;
        next_state = S_START;
      end
      S_START: begin
        cpu_s      = 1'b1;
        next_state = S_BUSY;
      end
      S_BUSY: begin
        if (cpu_w) begin
          done       = 1'b1;
          count_done = 1'b1;
          next_state = S_IDLE;
        end
`ifdef ISSUE_TIMEOUT_EN
        else if (to_hit) begin
          set_timeout = 1'b1;
          next_state  = S_HALT;
        end
`endif
      end
`ifdef ISSUE_TIMEOUT_EN
      S_HALT: next_state = S_HALT;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // cpu_in is captured on entry to LOAD so it is already valid while cpu_load is high
  always_ff @(posedge clk) begin
    if (reset)        cpu_in <= '0;
    else if (load_in) cpu_in <= head;
  end

  // sticky illegal flag and completion counter
  always_ff @(posedge clk) begin
    if (reset) begin
      err_illegal <= 1'b0;
      issued_cnt  <= '0;
    end else begin
      if (set_illegal) err_illegal <= 1'b1;
      if (count_done)  issued_cnt  <= issued_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_instr_issuer.sv
// tb/tb_cpu_instr_issuer.sv - scoreboard bench for cpu_instr_issuer with a behavioural cpu stub
module tb_cpu_instr_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        run;
  logic        cpu_w;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic        cpu_s;
  logic        busy;
  logic        done;
  logic        empty;
  logic        full;
  logic        err_illegal;
  logic        err_ovf;
  logic        err_timeout;
  logic [7:0]  issued_cnt;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int load_cnt = 0;
  logic [15:0] exp_q [$];

  logic [15:0] rf [8];
  logic [15:0] ir;
  logic [1:0]  ex_cnt;
  logic        stuck;

  cpu_instr_issuer dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .run         (run),
    .cpu_w       (cpu_w),
    .cpu_in      (cpu_in),
    .cpu_load    (cpu_load),
    .cpu_s       (cpu_s),
    .busy        (busy),
    .done        (done),
    .empty       (empty),
    .full        (full),
    .err_illegal (err_illegal),
    .err_ovf     (err_ovf),
    .err_timeout (err_timeout),
    .issued_cnt  (issued_cnt)
  );

  always #5 clk = ~clk;

  // cpu stub: MOV returns to wait one cycle after leaving it, ALU two cycles
  always @(posedge clk) begin
    if (reset) begin
      cpu_w  <= 1'b1;
      ex_cnt <= 2'd0;
      ir     <= 16'h0;
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
    end else begin
      if (cpu_load) ir <= cpu_in;
      if (cpu_s && cpu_w) begin
        cpu_w  <= 1'b0;
        ex_cnt <= (ir[15:13] == 3'b110) ? 2'd1 : 2'd2;
      end else if (!cpu_w && !stuck) begin
        ex_cnt <= ex_cnt - 2'd1;
        if (ex_cnt == 2'd1) begin
          cpu_w <= 1'b1;
          case (ir[15:11])
            5'b11010: rf[ir[10:8]] <= {{8{ir[7]}}, ir[7:0]};
            5'b11000: rf[ir[7:5]]  <= rf[ir[2:0]];
            5'b10100: rf[ir[7:5]]  <= rf[ir[10:8]] + rf[ir[2:0]];
            default: ;
          endcase
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every load must present the next expected word
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_load) begin
        load_cnt++;
        if (exp_q.size() == 0) chk("sb_unexpected_load", 32'(cpu_in), 32'hFFFF_FFFF);
        else                   chk("sb_cpu_in", 32'(cpu_in), 32'(exp_q.pop_front()));
        chk("load_without_s", 32'(cpu_s), 32'd0);
      end
      if (cpu_s) chk("s_only_when_cpu_waits", 32'(cpu_w), 32'd1);
      if (done) done_cnt++;
    end
  end

  task automatic push(input logic [15:0] w, input bit expect_issue);
    wr_en   = 1'b1;
    wr_data = w;
    if (expect_issue) exp_q.push_back(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && empty && cpu_w) break;
    end
    chk("wait_idle_bound", 32'(i < 400), 32'd1);
  endtask

  task automatic wait_load();
    int i;
    for (i = 0; i < 50; i++) begin
      if (cpu_load) break;
      @(negedge clk);
    end
    chk("wait_load_bound", 32'(i < 50), 32'd1);
  endtask

  task automatic wait_s();
    int i;
    for (i = 0; i < 50; i++) begin
      if (cpu_s) break;
      @(negedge clk);
    end
    chk("wait_s_bound", 32'(i < 50), 32'd1);
  endtask

  initial begin
    int l0;
    int d0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 16'h0;
    run     = 1'b0;
    stuck   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cpu_in", 32'(cpu_in), 32'd0);
    chk("rst_load_s", 32'({cpu_load, cpu_s, done}), 32'd0);
    chk("rst_errs", 32'({err_illegal, err_ovf, err_timeout}), 32'd0);
    chk("rst_issued", 32'(issued_cnt), 32'd0);
    reset = 1'b0;

    // single MOV R0,#7
    run = 1'b1;
    push(16'hD007, 1'b1);
    wait_load();
    @(negedge clk);
    chk("mov_s_after_load", 32'({cpu_load, cpu_s}), 32'b01);
    @(negedge clk);
    chk("mov_busy1_no_done", 32'({busy, done}), 32'b10);
    @(negedge clk);
    chk("mov_done_start_plus2", 32'(done), 32'd1);
    wait_idle();
    chk("mov_r0", 32'(rf[0]), 32'd7);
    chk("mov_issued", 32'(issued_cnt), 32'd1);

    // small program: R2 = R1 + R0
    push(16'hD007, 1'b1);
    push(16'hD102, 1'b1);
    push(16'hA140, 1'b1);
    wait_idle();
    chk("prog_r1", 32'(rf[1]), 32'd2);
    chk("prog_r2", 32'(rf[2]), 32'd9);
    chk("prog_issued", 32'(issued_cnt), 32'd4);

    // illegal word is screened out
    l0 = load_cnt;
    push(16'hE000, 1'b0);
    push(16'hD005, 1'b1);
    wait_idle();
    chk("ill_flag", 32'(err_illegal), 32'd1);
    chk("ill_one_load", 32'(load_cnt - l0), 32'd1);
    chk("ill_r0", 32'(rf[0]), 32'd5);
    chk("ill_issued", 32'(issued_cnt), 32'd5);

    // fill the buffer while paused, then overflow by one
    run = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(16'hD000 | 16'(i), i < 8);
      if (i == 6) chk("fill_not_full_at7", 32'(full), 32'd0);
      if (i == 7) chk("fill_full_at8", 32'(full), 32'd1);
      if (i == 7) chk("fill_no_ovf_yet", 32'(err_ovf), 32'd0);
    end
    chk("fill_ovf", 32'(err_ovf), 32'd1);
    chk("fill_paused_no_load", 32'(busy), 32'd0);
    d0 = done_cnt;
    run = 1'b1;
    wait_idle();
    chk("fill_done_pulses", 32'(done_cnt - d0), 32'd8);
    chk("fill_r0", 32'(rf[0]), 32'd7);
    chk("fill_issued", 32'(issued_cnt), 32'd13);
    chk("fill_sb_drained", 32'(exp_q.size()), 32'd0);

    // reset while an ADD is in BUSY
    push(16'hA140, 1'b1);
    wait_s();
    @(negedge clk);
    chk("rstmid_in_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_idle", 32'(busy), 32'd0);
    chk("rstmid_empty", 32'(empty), 32'd1);
    chk("rstmid_outs", 32'({cpu_load, cpu_s, done, err_illegal, err_ovf, err_timeout}), 32'd0);
    chk("rstmid_cpu_in", 32'(cpu_in), 32'd0);
    chk("rstmid_issued", 32'(issued_cnt), 32'd0);
    repeat (4) @(negedge clk);
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);

    // cpu never returns to wait
    stuck = 1'b1;
    push(16'hD009, 1'b1);
    wait_s();
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
`ifdef ISSUE_TIMEOUT_EN
      if (i == 16) chk("to_not_yet", 32'(err_timeout), 32'd0);
      if (i == 17) chk("to_flag", 32'(err_timeout), 32'd1);
`endif
    end
`ifdef ISSUE_TIMEOUT_EN
    chk("to_halt_held", 32'({busy, err_timeout, cpu_load, cpu_s}), 32'b1100);
`else
    chk("to_disabled", 32'({busy, err_timeout, done}), 32'b100);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stuck = 1'b0;
    chk("to_reset_clears", 32'({busy, err_timeout}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
